// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target (camera-side config bus model).
// Contents: responder FSM state enum, default write/read ID bytes, byte width.
package sccb_pkg;

  localparam int unsigned SCCB_BYTE_W = 8;

  // ID bytes for the default 7-bit device address 7'h21
  localparam logic [SCCB_BYTE_W-1:0] SCCB_WR_ID = 8'h42;
  localparam logic [SCCB_BYTE_W-1:0] SCCB_RD_ID = 8'h43;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ID,
    ACK_ID,
    SUB_ADDR,
    ACK_SUB,
    DATA_W,
    ACK_DW,
    DATA_R,
    NA_R,
    IGNORE
  } sccb_tgt_state_e;

endpackage

// File: rtl/sccb_target_if.sv
// SCCB target bus bundle: pad-side SCCB lines, committed-write report and debug read port.
//   scl_i, sda_i          : SCCB clock / data as seen on the pads (initiator -> target)
//   sda_oe                : 1 = target pulls SDA low (open drain)
//   wr_strobe/addr/data   : one-clk report of a committed register write
//   dbg_addr / dbg_data   : combinational read port into the register bank
//   busy                  : transfer in progress (START seen, no STOP yet)
// master = initiator / test side, slave = sccb_target.
interface sccb_target_if;

  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       busy;

  modport master (
    output scl_i, sda_i, dbg_addr,
    input  sda_oe, wr_strobe, wr_addr, wr_data, dbg_data, busy
  );

  modport slave (
    input  scl_i, sda_i, dbg_addr,
    output sda_oe, wr_strobe, wr_addr, wr_data, dbg_data, busy
  );

endinterface

// File: rtl/sccb_line_sync.sv
// Synchronises the asynchronous SCL/SDA pads into clk and produces 1-clk event pulses.
// Ports: clk, reset (async, active high), scl_i, sda_i (pads);
//        scl_rise, scl_fall, start_det, stop_det (registered pulses), sda_s (synced SDA
//        aligned with the pulses, used as the sampled bit on scl_rise).
// Every event appears 3 clk after the pad edge: 2 sync flops + 1 registered pulse.
module sccb_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_d;
  logic       sda_d;

  // Idle bus is high on both lines, so all history flops reset to 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_ff    <= 2'b11;
      sda_ff    <= 2'b11;
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_s     <= 1'b1;
    end else begin
      scl_ff    <= {scl_ff[0], scl_i};
      sda_ff    <= {sda_ff[0], sda_i};
      scl_d     <= scl_ff[1];
      sda_d     <= sda_ff[1];
      scl_rise  <= scl_ff[1] & ~scl_d;
      scl_fall  <= ~scl_ff[1] & scl_d;
      // SDA moving while SCL stays high marks START (falling) or STOP (rising)
      start_det <= scl_ff[1] & scl_d & sda_d & ~sda_ff[1];
      stop_det  <= scl_ff[1] & scl_d & ~sda_d & sda_ff[1];
      sda_s     <= sda_ff[1];
    end
  end

endmodule

// File: rtl/sccb_target.sv
// SCCB responder with a 256x8 register bank (camera model for the OV7670 config bus).
// Decodes 3-phase writes (ID, sub-address, data) and 2-phase write + 2-phase read cycles.
// Ports: clk, reset (async, active high), bus (sccb_target_if.slave): SCCB pads, open-drain
//        sda_oe, committed-write report, combinational debug read port, busy.
// Parameters: DEV_ID (7-bit device address), REG_INIT (reset value of every bank entry).
// Build option: define SCCB_TARGET_ACK_EN to pull SDA low in the ACK slots of a matching
//   ID; otherwise the ACK bit is left as a don't-care and SDA is driven only on reads.
module sccb_target #(
  parameter logic [6:0] DEV_ID   = 7'h21,
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic         clk,
  input  logic         reset,
  sccb_target_if.slave bus
);

  localparam int unsigned BYTE_W = sccb_pkg::SCCB_BYTE_W;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DEPTH  = 256;
  localparam logic [BYTE_W-1:0] WR_ID = {DEV_ID, 1'b0};
  localparam logic [BYTE_W-1:0] RD_ID = {DEV_ID, 1'b1};
`ifdef SCCB_TARGET_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  sccb_pkg::sccb_tgt_state_e state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [BYTE_W-1:0] shreg, shreg_n;
  logic [BYTE_W-1:0] ptr, ptr_n;
  logic [BYTE_W-1:0] wr_addr_q, wr_addr_n;
  logic [BYTE_W-1:0] wr_data_q, wr_data_n;
  logic              sda_oe_q, sda_oe_n;
  logic              wr_strobe_q, wr_strobe_n;
  logic              busy_q, busy_n;
  logic              bank_we;
  logic [BYTE_W-1:0] bank [DEPTH];

  logic              scl_rise, scl_fall, start_det, stop_det, sda_s;
  logic [BYTE_W-1:0] byte_in;
  logic [BYTE_W-1:0] rd_byte;
  logic              last_bit;
  logic              id_match;

  sccb_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (bus.scl_i),
    .sda_i     (bus.sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign byte_in  = {shreg[BYTE_W-2:0], sda_s};
  assign last_bit = (bit_cnt == CNT_W'(BYTE_W - 1));
  assign id_match = (shreg == WR_ID) || (shreg == RD_ID);
  // Pointer is stable for the whole read phase, so the bank can be indexed directly
  assign rd_byte  = bank[ptr];

  assign bus.sda_oe    = sda_oe_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_data  = bank[bus.dbg_addr];

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= sccb_pkg::IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      ptr         <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      ptr         <= ptr_n;
      wr_addr_q   <= wr_addr_n;
      wr_data_q   <= wr_data_n;
      sda_oe_q    <= sda_oe_n;
      wr_strobe_q <= wr_strobe_n;
      busy_q      <= busy_n;
    end
  end

  // Register bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) bank[i] <= REG_INIT;
    end else if (bank_we) begin
      bank[ptr] <= byte_in;
    end
  end

  // Next state: bits advance on SCL rise, SDA drive changes only on SCL fall
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    ptr_n       = ptr;
    wr_addr_n   = wr_addr_q;
    wr_data_n   = wr_data_q;
    sda_oe_n    = sda_oe_q;
    wr_strobe_n = 1'b0;
    busy_n      = busy_q;
    bank_we     = 1'b0;

    if (start_det) begin
      // Repeated START is honoured anywhere; any partial byte is dropped
      state_n   = sccb_pkg::DEV_ID;
      bit_cnt_n = '0;
      busy_n    = 1'b1;
    end else if (stop_det) begin
      state_n   = sccb_pkg::IDLE;
      bit_cnt_n = '0;
      busy_n    = 1'b0;
    end else if (scl_rise) begin
      case (state)
        sccb_pkg::DEV_ID: begin
          shreg_n   = byte_in;
          bit_cnt_n = bit_cnt + CNT_W'(1);
          if (last_bit) state_n = sccb_pkg::ACK_ID;
        end
        sccb_pkg::ACK_ID: begin
          bit_cnt_n = '0;
          if (shreg == WR_ID)      state_n = sccb_pkg::SUB_ADDR;
          else if (shreg == RD_ID) state_n = sccb_pkg::DATA_R;
          else                     state_n = sccb_pkg::IGNORE;
        end
        sccb_pkg::SUB_ADDR: begin
          shreg_n   = byte_in;
          bit_cnt_n = bit_cnt + CNT_W'(1);
          if (last_bit) begin
            ptr_n   = byte_in;
            state_n = sccb_pkg::ACK_SUB;
          end
        end
        sccb_pkg::ACK_SUB: begin
          bit_cnt_n = '0;
          state_n   = sccb_pkg::DATA_W;
        end
        sccb_pkg::DATA_W: begin
          shreg_n   = byte_in;
          bit_cnt_n = bit_cnt + CNT_W'(1);
          if (last_bit) begin
            bank_we     = 1'b1;
            wr_strobe_n = 1'b1;
            wr_addr_n   = ptr;
            wr_data_n   = byte_in;
            state_n     = sccb_pkg::ACK_DW;
          end
        end
        sccb_pkg::ACK_DW: state_n = sccb_pkg::IGNORE;
        sccb_pkg::DATA_R: begin
          bit_cnt_n = bit_cnt + CNT_W'(1);
          if (last_bit) state_n = sccb_pkg::NA_R;
        end
        sccb_pkg::NA_R:   state_n = sccb_pkg::IGNORE;
        default:          state_n = state;
      endcase
    end else if (scl_fall) begin
      case (state)
        sccb_pkg::ACK_ID:                  sda_oe_n = ACK_EN && id_match;
        sccb_pkg::ACK_SUB, sccb_pkg::ACK_DW: sda_oe_n = ACK_EN;
        // Open drain: a 0 bit is driven low, a 1 bit is released
        sccb_pkg::DATA_R:                  sda_oe_n = ~rd_byte[CNT_W'(BYTE_W - 1) - bit_cnt];
        default:                           sda_oe_n = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: bit-banged SCCB initiator, write scoreboard,
// ACK-slot and read-back checks, async reset abort.
module tb_sccb_target;
  import sccb_pkg::*;

`ifdef SCCB_TARGET_ACK_EN
  localparam logic ACK_EXP = 1'b1;
`else
  localparam logic ACK_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic m_sda;
  int   total = 0;
  int   bad = 0;
  int   q = 200;
  logic oe_seen = 1'b0;
  logic prev_strobe = 1'b0;
  logic [15:0] wq[$];
  logic [7:0]  rq[$];
  logic [7:0]  rd;
  logic [15:0] exp_w;

  sccb_target_if bus ();

  // Open-drain pad: low if either side pulls
  assign bus.sda_i = m_sda & ~bus.sda_oe;

  sccb_target dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every strobe must match the oldest pending expected write
  always @(negedge clk) begin
    if (bus.sda_oe === 1'b1) oe_seen = 1'b1;
    if (bus.wr_strobe === 1'b1) begin
      check("strobe_single_clk", 32'(prev_strobe), 32'(0));
      check("strobe_expected", 32'(wq.size() != 0), 32'(1));
      if (wq.size() != 0) begin
        exp_w = wq.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(exp_w[15:8]));
        check("wr_data", 32'(bus.wr_data), 32'(exp_w[7:0]));
      end
    end
    prev_strobe = bus.wr_strobe;
  end

  task automatic sccb_start();
    m_sda = 1'b1; #(q);
    bus.scl_i = 1'b1; #(q);
    m_sda = 1'b0; #(q);
    bus.scl_i = 1'b0; #(q);
  endtask

  task automatic sccb_stop();
    m_sda = 1'b0; #(q);
    bus.scl_i = 1'b1; #(q);
    m_sda = 1'b1; #(q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; #(q);
    bus.scl_i = 1'b1; #(2 * q);
    bus.scl_i = 1'b0; #(q);
  endtask

  // Released bit slot; returns pad level and target drive at mid-high
  task automatic clock_in(output logic pad, output logic oe);
    m_sda = 1'b1; #(q);
    bus.scl_i = 1'b1; #(q);
    pad = bus.sda_i;
    oe  = bus.sda_oe;
    #(q);
    bus.scl_i = 1'b0; #(q);
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag, input logic exp_ack);
    logic pad, oe;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    clock_in(pad, oe);
    check({tag, "_ack"}, 32'(oe), 32'(exp_ack));
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic pad, oe;
    for (int i = 7; i >= 0; i--) begin
      clock_in(pad, oe);
      b[i] = pad;
    end
    send_bit(1'b1);
  endtask

  task automatic dbg_check(input logic [7:0] addr, input string tag, input logic [7:0] exp);
    bus.dbg_addr = addr;
    #20;
    check(tag, 32'(bus.dbg_data), 32'(exp));
  endtask

  initial begin
    reset = 1'b1;
    m_sda = 1'b1;
    bus.scl_i = 1'b1;
    bus.dbg_addr = 8'h12;
    #102;
    check("rst_sda_oe", 32'(bus.sda_oe), 32'(0));
    check("rst_wr_strobe", 32'(bus.wr_strobe), 32'(0));
    check("rst_wr_addr", 32'(bus.wr_addr), 32'(0));
    check("rst_wr_data", 32'(bus.wr_data), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_bank", 32'(bus.dbg_data), 32'(0));
    reset = 1'b0;
    #100;

    // 1: full write at ~400 kHz
    q = 630;
    oe_seen = 1'b0;
    wq.push_back({8'h12, 8'h80});
    sccb_start();
    check("t1_busy", 32'(bus.busy), 32'(1));
    send_byte(SCCB_WR_ID, "t1_id", ACK_EXP);
    send_byte(8'h12, "t1_sub", ACK_EXP);
    send_byte(8'h80, "t1_data", ACK_EXP);
    sccb_stop();
    #(q);
    check("t1_busy_after_stop", 32'(bus.busy), 32'(0));
    check("t1_oe_seen", 32'(oe_seen), 32'(ACK_EXP));
    check("t1_sb_drained", 32'(wq.size()), 32'(0));
    dbg_check(8'h12, "t1_bank12", 8'h80);

    // 2: pointer set, read, write, re-read
    q = 200;
    sccb_start();
    send_byte(SCCB_WR_ID, "t2_id", ACK_EXP);
    send_byte(8'h0A, "t2_sub", ACK_EXP);
    sccb_stop();
    #(q);
    rq.push_back(8'h00);
    sccb_start();
    send_byte(SCCB_RD_ID, "t2_rdid", ACK_EXP);
    read_byte(rd);
    check("t2_read0", 32'(rd), 32'(rq.pop_front()));
    sccb_stop();
    #(q);
    check("t2_busy_after_stop", 32'(bus.busy), 32'(0));
    wq.push_back({8'h0A, 8'h5C});
    sccb_start();
    send_byte(SCCB_WR_ID, "t2w_id", ACK_EXP);
    send_byte(8'h0A, "t2w_sub", ACK_EXP);
    send_byte(8'h5C, "t2w_data", ACK_EXP);
    sccb_stop();
    #(q);
    rq.push_back(8'h5C);
    sccb_start();
    send_byte(SCCB_RD_ID, "t2_rdid2", ACK_EXP);
    read_byte(rd);
    check("t2_read1", 32'(rd), 32'(rq.pop_front()));
    sccb_stop();
    #(q);

    // 3: foreign device ID is ignored entirely
    oe_seen = 1'b0;
    sccb_start();
    send_byte(8'h60, "t3_id", 1'b0);
    send_byte(8'h12, "t3_sub", 1'b0);
    send_byte(8'h80, "t3_data", 1'b0);
    sccb_stop();
    #(q);
    check("t3_oe_seen", 32'(oe_seen), 32'(0));
    dbg_check(8'h12, "t3_bank12", 8'h80);

    // 4: partial data byte then STOP; partial byte then repeated START
    sccb_start();
    send_byte(SCCB_WR_ID, "t4a_id", ACK_EXP);
    send_byte(8'h12, "t4a_sub", ACK_EXP);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    sccb_stop();
    #(q);
    dbg_check(8'h12, "t4a_bank12", 8'h80);
    wq.push_back({8'h13, 8'hAA});
    sccb_start();
    send_byte(SCCB_WR_ID, "t4b_id", ACK_EXP);
    send_byte(8'h12, "t4b_sub", ACK_EXP);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    sccb_start();
    send_byte(SCCB_WR_ID, "t4c_id", ACK_EXP);
    send_byte(8'h13, "t4c_sub", ACK_EXP);
    send_byte(8'hAA, "t4c_data", ACK_EXP);
    sccb_stop();
    #(q);
    dbg_check(8'h12, "t4_bank12", 8'h80);
    dbg_check(8'h13, "t4_bank13", 8'hAA);

    // 5: asynchronous reset in the data phase, then a clean write
    sccb_start();
    send_byte(SCCB_WR_ID, "t5_id", ACK_EXP);
    send_byte(8'h01, "t5_sub", ACK_EXP);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_busy", 32'(bus.busy), 32'(0));
    check("t5_rst_sda_oe", 32'(bus.sda_oe), 32'(0));
    check("t5_rst_wr_addr", 32'(bus.wr_addr), 32'(0));
    check("t5_rst_wr_data", 32'(bus.wr_data), 32'(0));
    check("t5_rst_strobe", 32'(bus.wr_strobe), 32'(0));
    #50;
    bus.scl_i = 1'b1;
    m_sda = 1'b1;
    #50;
    reset = 1'b0;
    #(q);
    dbg_check(8'h12, "t5_bank12_reinit", 8'h00);
    wq.push_back({8'h01, 8'hFF});
    sccb_start();
    send_byte(SCCB_WR_ID, "t5w_id", ACK_EXP);
    send_byte(8'h01, "t5w_sub", ACK_EXP);
    send_byte(8'hFF, "t5w_data", ACK_EXP);
    sccb_stop();
    #(q);
    dbg_check(8'h01, "t5_bank01", 8'hFF);
    check("t5_busy", 32'(bus.busy), 32'(0));

    #100;
    check("sb_empty", 32'(wq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
